// File: rtl/snd_pkg.sv
// Shared decode constant and NMI state encoding for the sound command path.
package snd_pkg;

    localparam logic [2:0] SND_LATCH_SEL = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        GAP
    } nmi_state_t;

endpackage

// File: rtl/snd_cmd_fifo.sv
// Small command FIFO used by snd_cmd_latch when SND_CMD_FIFO_EN is defined.
// Pointers wrap modulo 2**DEPTH_LOG2; push when full is ignored unless paired with a pop.
module snd_cmd_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = DEPTH[DEPTH_LOG2:0];

    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/snd_cmd_latch.sv
// Main-CPU to audio-CPU sound command latch with edge-friendly NMI generation.
// Define SND_CMD_FIFO_EN for a 2**DEPTH_LOG2 command FIFO; otherwise a single-entry latch.
module snd_cmd_latch
    import snd_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int NMI_GAP    = 2
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic [7:0]  mcpu_dout,
    input  logic        snd_write,
    input  logic        acpu_cen,
    input  logic [15:0] acpu_ab,
    input  logic        acpu_rw,
    output logic [7:0]  cmd_dout,
    output logic        acpu_nmi,
    output logic        cmd_pending,
    output logic        cmd_ovf
);

    localparam int GAP_W = $clog2(NMI_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = NMI_GAP[GAP_W-1:0];
    localparam logic [GAP_W-1:0] GAP_ONE  = 1;

    if (NMI_GAP < 1 || DEPTH_LOG2 < 1) begin : g_bad_cfg
        $error("snd_cmd_latch: NMI_GAP and DEPTH_LOG2 must both be >= 1");
    end

    nmi_state_t     state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic           ovf_q, ovf_d;
    logic           rd, pop;
    logic           unused_ab;

    assign unused_ab = ^acpu_ab[12:0];
    assign rd        = acpu_cen & acpu_rw & (acpu_ab[15:13] == SND_LATCH_SEL);
    assign pop       = rd & cmd_pending;
    assign cmd_ovf   = ovf_q;
    assign acpu_nmi  = (state_q == ASSERT);

`ifdef SND_CMD_FIFO_EN
    logic       fifo_full, fifo_empty, fifo_push;
    logic [7:0] fifo_head;
    logic [7:0] last_q, last_d;

    assign fifo_push   = snd_write & (~fifo_full | pop);
    assign cmd_pending = ~fifo_empty;
    // Once drained, keep showing the byte that was last at the head.
    assign cmd_dout    = fifo_empty ? last_q : fifo_head;

    snd_cmd_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (pop),
        .din     (mcpu_dout),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        last_d = fifo_empty ? last_q : fifo_head;
        ovf_d  = ovf_q | (snd_write & fifo_full & ~pop);
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            last_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            last_q <= last_d;
            ovf_q  <= ovf_d;
        end
    end
`else
    logic [7:0] latch_q, latch_d;
    logic       pending_q, pending_d;

    assign cmd_pending = pending_q;
    assign cmd_dout    = latch_q;

    always_comb begin
        latch_d   = snd_write ? mcpu_dout : latch_q;
        pending_d = snd_write | (pending_q & ~pop);
        ovf_d     = ovf_q | (snd_write & pending_q & ~pop);
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            latch_q   <= '0;
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            latch_q   <= latch_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end
`endif

    // IDLE reacts every clock; the gap only counts audio-CPU enables.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (cmd_pending) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (pop) begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (acpu_cen) begin
                    if (gap_q == '0) begin
                        state_d = cmd_pending ? ASSERT : IDLE;
                    end else begin
                        gap_d = gap_q - GAP_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_snd_cmd_latch.sv
// Randomised self-checking bench for snd_cmd_latch against a queue-based reference model.
module tb_snd_cmd_latch;

    localparam int NMI_GAP    = 2;
    localparam int DEPTH_LOG2 = 2;
`ifdef SND_CMD_FIFO_EN
    localparam int CAP = 1 << DEPTH_LOG2;
`else
    localparam int CAP = 1;
`endif

    logic        clk_sys;
    logic        rst_n;
    logic [7:0]  mcpu_dout;
    logic        snd_write;
    logic        acpu_cen;
    logic [15:0] acpu_ab;
    logic        acpu_rw;
    logic [7:0]  cmd_dout;
    logic        acpu_nmi;
    logic        cmd_pending;
    logic        cmd_ovf;

    snd_cmd_latch #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .NMI_GAP    (NMI_GAP)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .mcpu_dout   (mcpu_dout),
        .snd_write   (snd_write),
        .acpu_cen    (acpu_cen),
        .acpu_ab     (acpu_ab),
        .acpu_rw     (acpu_rw),
        .cmd_dout    (cmd_dout),
        .acpu_nmi    (acpu_nmi),
        .cmd_pending (cmd_pending),
        .cmd_ovf     (cmd_ovf)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Reference model state: queued commands, visible byte, NMI level and gap budget.
    logic [7:0] mQueue [$];
    logic [7:0] mDout;
    bit         mOvf;
    bit         mNmi;
    int         mGap;

    int checks;
    int failures;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelStep(input bit rstn, input bit wr, input logic [7:0] data,
                             input bit cen, input bit rw, input logic [15:0] ab);
        bit pend, rdHit, popNow;
        if (!rstn) begin
            mQueue.delete();
            mDout = 8'h00;
            mOvf  = 1'b0;
            mNmi  = 1'b0;
            mGap  = -1;
            return;
        end
        pend   = (mQueue.size() > 0);
        rdHit  = cen && rw && (ab >= 16'h6000) && (ab <= 16'h7FFF);
        popNow = rdHit && pend;

        if (mGap >= 0) begin
            if (cen) begin
                if (mGap == 0) begin
                    mGap = -1;
                    mNmi = pend;
                end else begin
                    mGap = mGap - 1;
                end
            end
        end else if (mNmi) begin
            if (popNow) begin
                mNmi = 1'b0;
                mGap = NMI_GAP;
            end
        end else if (pend) begin
            mNmi = 1'b1;
        end

`ifdef SND_CMD_FIFO_EN
        if (popNow) void'(mQueue.pop_front());
        if (wr) begin
            if (mQueue.size() == CAP) mOvf = 1'b1;
            else mQueue.push_back(data);
        end
`else
        if (wr && pend && !popNow) mOvf = 1'b1;
        if (popNow) mQueue.delete();
        if (wr) begin
            mQueue.delete();
            mQueue.push_back(data);
        end
`endif
        if (mQueue.size() > 0) mDout = mQueue[0];
    endtask

    task automatic applyStimulus(input bit rstn, input bit wr, input logic [7:0] data,
                                 input bit cen, input bit rw, input logic [15:0] ab);
        rst_n     = rstn;
        snd_write = wr;
        mcpu_dout = data;
        acpu_cen  = cen;
        acpu_rw   = rw;
        acpu_ab   = ab;
        @(posedge clk_sys);
        modelStep(rstn, wr, data, cen, rw, ab);
        #1;
        checkOutput("cmd_dout", cmd_dout, mDout);
        checkOutput("acpu_nmi", {7'b0, acpu_nmi}, {7'b0, mNmi});
        checkOutput("cmd_pending", {7'b0, cmd_pending}, {7'b0, (mQueue.size() > 0)});
        checkOutput("cmd_ovf", {7'b0, cmd_ovf}, {7'b0, mOvf});
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 8'h00, i[0], 1, 16'h0000);
    endtask

    task automatic writeCmd(input logic [7:0] b);
        applyStimulus(1, 1, b, 0, 1, 16'h0000);
    endtask

    task automatic readAt(input logic [15:0] ab);
        applyStimulus(1, 0, 8'h00, 1, 1, ab);
    endtask

    task automatic doReset();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'hFF, 1, 1, 16'h6000);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        snd_write = 1'b0;
        mcpu_dout = 8'h00;
        acpu_cen  = 1'b0;
        acpu_rw   = 1'b0;
        acpu_ab   = 16'h0000;

        doReset();
        idleCycles(3);

        $display("[TB] single command");
        writeCmd(8'hA5);
        idleCycles(3);
        readAt(16'h6000);
        idleCycles(10);

        $display("[TB] back-to-back commands");
        writeCmd(8'h11);
        writeCmd(8'h22);
        writeCmd(8'h33);
        for (int i = 0; i < 3; i++) begin
            idleCycles(8);
            readAt(16'h7FFF);
        end
        idleCycles(10);

        $display("[TB] overflow");
        doReset();
        for (int i = 1; i <= 5; i++) writeCmd(i[7:0]);
        for (int i = 0; i < 5; i++) begin
            idleCycles(8);
            readAt(16'h6123);
        end
        idleCycles(10);

        $display("[TB] simultaneous write and pop");
        doReset();
        for (int i = 1; i <= CAP; i++) writeCmd(8'h40 + i[7:0]);
        idleCycles(3);
        applyStimulus(1, 1, 8'h66, 1, 1, 16'h6000);
        for (int i = 0; i < CAP + 1; i++) begin
            idleCycles(8);
            readAt(16'h6000);
        end
        idleCycles(10);
        applyStimulus(1, 1, 8'h77, 1, 1, 16'h6000);
        idleCycles(8);
        readAt(16'h6000);
        idleCycles(10);

        $display("[TB] non-latch accesses");
        writeCmd(8'h5A);
        idleCycles(3);
        readAt(16'h2000);
        readAt(16'h8000);
        applyStimulus(1, 0, 8'h00, 1, 0, 16'h6000);
        readAt(16'h5FFF);
        idleCycles(3);
        readAt(16'h6000);
        idleCycles(10);

        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            bit          wr, cen, rw, rstn;
            logic [15:0] ab;
            logic [7:0]  data;
            rstn = ($urandom_range(0, 499) != 0);
            wr   = ($urandom_range(0, 5) == 0);
            cen  = ($urandom_range(0, 1) == 1);
            rw   = ($urandom_range(0, 3) != 0);
            data = 8'($urandom);
            ab   = 16'($urandom);
            if ($urandom_range(0, 2) != 0) ab[15:13] = 3'b011;
            applyStimulus(rstn, wr, data, cen, rw, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
